// File: rtl/unified_mem_ctrl.sv
// Shared 128-bit block memory serving the instruction-cache and data-cache
// refill/write-back ports. One access runs at a time. Contention is resolved
// round-robin against the port granted last.
//
// Ports:
//   CLK, RESET         rising-edge clock, asynchronous active-low reset
//   I_READ/I_ADDRESS   instruction block read request and address
//   I_READDATA         last block read for the instruction port
//   I_BUSYWAIT         instruction port stall
//   D_READ/D_WRITE     data block read / write-back request (both high = write)
//   D_ADDRESS          data block address
//   D_WRITEDATA        write-back block
//   D_READDATA         last block read for the data port
//   D_BUSYWAIT         data port stall
module unified_mem_ctrl #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         I_READ,
  input  logic [27:0]  I_ADDRESS,
  output logic [127:0] I_READDATA,
  output logic         I_BUSYWAIT,
  input  logic         D_READ,
  input  logic         D_WRITE,
  input  logic [27:0]  D_ADDRESS,
  input  logic [127:0] D_WRITEDATA,
  output logic [127:0] D_READDATA,
  output logic         D_BUSYWAIT
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                  state_q;
  logic                    gnt_q;       // 0 = instruction port, 1 = data port
  logic                    last_gnt_q;
  logic [3:0]              cnt_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [127:0]            wdata_q;
  logic                    write_q;
  logic [127:0]            i_rdata_q;
  logic [127:0]            d_rdata_q;
  logic [127:0]            mem_q [Depth];

  logic i_req;
  logic d_req;
  logic grant_d;
  logic addr_unused;

  always_comb begin
    i_req   = I_READ;
    d_req   = D_READ | D_WRITE;
    // With both requesting, the port not served last wins.
    grant_d = (i_req && d_req) ? ~last_gnt_q : d_req;
  end

  // Upper address bits select nothing; addresses wrap onto the array.
  assign addr_unused = ^{I_ADDRESS[27:DEPTH_LOG2], D_ADDRESS[27:DEPTH_LOG2]};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_req || d_req) begin
            gnt_q   <= grant_d;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= StBusy;
            if (grant_d) begin
              idx_q   <= D_ADDRESS[DEPTH_LOG2-1:0];
              wdata_q <= D_WRITEDATA;
              write_q <= D_WRITE;
            end else begin
              idx_q   <= I_ADDRESS[DEPTH_LOG2-1:0];
              write_q <= 1'b0;
            end
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (write_q) begin
              mem_q[idx_q] <= wdata_q;
            end else if (gnt_q) begin
              d_rdata_q <= mem_q[idx_q];
            end else begin
              i_rdata_q <= mem_q[idx_q];
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          last_gnt_q <= gnt_q;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign I_READDATA = i_rdata_q;
  assign D_READDATA = d_rdata_q;
  assign I_BUSYWAIT = i_req & ~((state_q == StDone) & ~gnt_q);
  assign D_BUSYWAIT = d_req & ~((state_q == StDone) & gnt_q);

endmodule

// File: doc/unified_mem_ctrl.md
UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning array access delay in clock edges (legal range 1..15).
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of 128-bit block entries.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named CLK and RESET.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RESET  input  1  asynchronous active-low reset.
REQ-006 I_READ  input  1  instruction-cache block read request.
REQ-007 I_ADDRESS  input  28  instruction block address.
REQ-008 I_READDATA  output  128  instruction block read data.
REQ-009 I_BUSYWAIT  output  1  instruction port stall.
REQ-010 D_READ  input  1  data-cache block read request.
REQ-011 D_WRITE  input  1  data-cache block write-back request.
REQ-012 D_ADDRESS  input  28  data block address.
REQ-013 D_WRITEDATA  input  128  write-back block.
REQ-014 D_READDATA  output  128  data block read data.
REQ-015 D_BUSYWAIT  output  1  data port stall.

Function
REQ-016 SHALL be the memory-side responder to the CPU's i_cache and d_cache refill/write-back requests over one shared array of 2^DEPTH_LOG2 x 128 bits.
REQ-017 SHALL use the low DEPTH_LOG2 address bits as the array index; upper bits are ignored, so addresses wrap around.
REQ-018 SHALL implement FSM states IDLE, BUSY, DONE, plus a registered grant bit GNT (0 = I, 1 = D) and a down-counter CNT.
REQ-019 IDLE, when the D request (D_READ|D_WRITE) and/or I_READ is high at a rising edge:
- grant goes to the port not granted last (round-robin);
- grant goes to the only requester if just one is high;
- the granted port's address, write data and op are latched;
- CNT <= LATENCY-1; next state is BUSY.
REQ-020 BUSY, each edge: if CNT != 0 then CNT decrements; if CNT == 0 then the array access is performed and next state is DONE.
REQ-021 Array access on a read: the 128-bit entry is captured into the granted port's READDATA register.
REQ-022 Array access on a write: the latched data is written to the entry, and READDATA is unchanged.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE; last-grant is updated to GNT.
REQ-024 x_BUSYWAIT SHALL equal (port request high) AND NOT (state==DONE AND GNT==port), combinationally.
- BUSYWAIT deasserts LATENCY+1 edges after the request is sampled in IDLE.
REQ-025 An ungranted pending port SHALL keep BUSYWAIT high and be served on the first IDLE edge after the current DONE.
REQ-026 A request deasserted while BUSY SHALL NOT abort the access; the operation completes, and READDATA is updated for a read.
REQ-027 D_READ and D_WRITE high together SHALL be treated as a write.
REQ-028 I_READDATA and D_READDATA SHALL hold their value until the next read completes on the same port.
REQ-029 Input changes during BUSY/DONE SHALL NOT affect the latched operation.
REQ-030 At least one IDLE cycle SHALL separate consecutive accesses, giving a minimum period of LATENCY+2 cycles.

Reset
REQ-031 RESET low SHALL immediately set state IDLE, CNT 0, last-grant I (so D wins the first contention), and I_READDATA/D_READDATA to 0.
REQ-032 RESET low SHALL clear every array entry to 0.
REQ-033 RESET asserted mid-BUSY SHALL abort the operation: no array write and no READDATA update.
REQ-034 While RESET is low, BUSYWAIT outputs SHALL still follow REQ-024 (state IDLE, so BUSYWAIT = request).

Verification
REQ-035 Write then read, LATENCY=4:
- D_WRITE addr 0x0000005, data 0x0123..CDEF -> D_BUSYWAIT high 5 cycles, low in 6th;
- then D_READ 0x0000005 -> D_READDATA=0x0123..CDEF on the BUSYWAIT-low cycle.
REQ-036 Contention after reset: I_READ and D_READ raised in the same cycle -> D served first (D_BUSYWAIT low at edge 5), then I_BUSYWAIT low 6 cycles later (at edge 11).
REQ-037 Round-robin: after an I access, I_READ and D_WRITE pending together -> D granted; after that D access, with both pending again -> I granted.
REQ-038 Wrap-around: write 0xAA..AA to address 0x0000103 (DEPTH_LOG2=8), read 0x0000003 -> 0xAA..AA.
REQ-039 Reset mid-write: assert RESET low 2 cycles into a D_WRITE -> state IDLE, and a later read of that address returns 0.
REQ-040 Abandoned read: D_READ dropped while BUSY -> the FSM still passes through DONE and updates D_READDATA; a following I_READ is served normally.
